// File: rtl/gbdt_node_loader.sv
// gbdt_node_loader: host-side writer for the GBDT node RAM image.
// It takes a stream of tree headers and node words, and fills in the leaf
// linkage fields (next_tree, is_last_tree). It then writes the packed words to
// consecutive RAM addresses starting at 0.
//
// Input handshake: a beat transfers on a clock edge where in_valid and in_ready
// are both high. in_ready is combinational from state, eng_idle and load_err.
// The source holds in_valid, in_hdr and in_data stable until the beat transfers.
module gbdt_node_loader #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int MAX_NODES = 16384
) (
    input  logic              gbdt_clk,
    input  logic              gbdt_rst,
    input  logic              load_start,
    input  logic              eng_idle,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_hdr,
    input  logic [DATA_W-1:0] in_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HDR   = 2'd1;
    localparam logic [1:0] ST_NODES = 2'd2;

    // The sum width leaves headroom so that base+cnt never wraps before the
    // overflow and child-range compares.
    localparam int SW = ADDR_W + 2;
    localparam logic [SW-1:0] MAX_V = SW'(MAX_NODES);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;       // reaches MAX_NODES after the final write
    logic [ADDR_W:0]   tree_base_q, tree_base_d;
    logic [13:0]       cnt_q, cnt_d;
    logic [13:0]       remaining_q, remaining_d;
    logic              last_q, last_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              done_pend_q, done_pend_d; // final write issued; load_done follows the write cycle
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;

    logic              accept;
    logic [13:0]       hdr_cnt;
    logic              hdr_last;
    logic [SW-1:0]     hdr_end;
    logic [SW-1:0]     tree_end;
    logic [SW-1:0]     child_l;
    logic [SW-1:0]     child_r;
    logic              child_bad;
    logic [ADDR_W-1:0] next_tree;
    logic [DATA_W-1:0] node_word;

    // Combinational outputs and datapath helpers for the current beat.
    always_comb begin
        in_ready  = (state_q == ST_HDR || state_q == ST_NODES) && eng_idle && !load_err_q;
        accept    = in_valid && in_ready;
        hdr_cnt   = in_data[13:0];
        hdr_last  = in_data[14];
        hdr_end   = SW'(wr_ptr_q) + SW'(hdr_cnt);
        tree_end  = SW'(tree_base_q) + SW'(cnt_q);
        // Children are relative to the node's own address; both must stay inside this tree.
        child_l   = SW'(wr_ptr_q) + SW'(in_data[14:8]);
        child_r   = SW'(wr_ptr_q) + SW'(in_data[7:1]);
        child_bad = !in_data[0] && ((child_l >= tree_end) || (child_r >= tree_end));
        next_tree = last_q ? '0 : tree_end[ADDR_W-1:0];
        // Leaf: keep leaf_val and replace the low half with the linkage fields.
        node_word = in_data[0] ? {in_data[31:16], next_tree, last_q, 1'b1} : in_data;
    end

    // Next-state logic: the FSM, the pointers and the registered RAM write port.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        tree_base_d = tree_base_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        last_d      = last_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        done_pend_d = 1'b0;
        load_done_d = done_pend_q;
        load_err_d  = load_err_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d     = ST_HDR;
                    wr_ptr_d    = '0;
                    tree_base_d = '0;
                    load_err_d  = 1'b0;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    if (!in_hdr || hdr_cnt == 14'd0 || hdr_end > MAX_V) begin
                        load_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d       = hdr_cnt;
                        last_d      = hdr_last;
                        tree_base_d = wr_ptr_q;
                        remaining_d = hdr_cnt;
                        state_d     = ST_NODES;
                    end
                end
            end
            ST_NODES: begin
                if (accept) begin
                    if (in_hdr || child_bad) begin
                        load_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        ram_we_d    = 1'b1;
                        ram_addr_d  = wr_ptr_q[ADDR_W-1:0];
                        ram_wdata_d = node_word;
                        wr_ptr_d    = wr_ptr_q + (ADDR_W+1)'(1);
                        remaining_d = remaining_q - 14'd1;
                        if (remaining_q == 14'd1) begin
                            if (last_q) begin
                                state_d     = ST_IDLE;
                                done_pend_d = 1'b1;
                            end else begin
                                state_d = ST_HDR;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge gbdt_clk or posedge gbdt_rst) begin
        if (gbdt_rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            tree_base_q <= '0;
            cnt_q       <= '0;
            remaining_q <= '0;
            last_q      <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            done_pend_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            tree_base_q <= tree_base_d;
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
            last_q      <= last_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            done_pend_q <= done_pend_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gbdt_node_loader.sv
// Directed bench for gbdt_node_loader. Each stimulus task pushes the expected RAM write
// onto exp_q. A monitor running on the falling edge pops from exp_q and compares every
// ram_we beat, and also checks the load_done pulse that follows the final write.
module tb_gbdt_node_loader;
  logic        gbdt_clk = 1'b0;
  logic        gbdt_rst;
  logic        load_start, eng_idle, in_valid, in_hdr;
  logic [31:0] in_data;
  logic        in_ready, ram_we, busy, load_done, load_err;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [1:0]  dbg_state;

  // {done_after, addr[13:0], data[31:0]}
  logic [46:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [13:0] exp_addr;
  logic        done_next = 1'b0;

  gbdt_node_loader dut (
    .gbdt_clk(gbdt_clk), .gbdt_rst(gbdt_rst), .load_start(load_start), .eng_idle(eng_idle),
    .in_valid(in_valid), .in_ready(in_ready), .in_hdr(in_hdr), .in_data(in_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .busy(busy),
    .load_done(load_done), .load_err(load_err), .dbg_state(dbg_state)
  );

  // clock
  always #5 gbdt_clk = ~gbdt_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [46:0] e;
    logic        exp_done;
    forever begin
      @(negedge gbdt_clk);
      exp_done  = done_next;
      done_next = 1'b0;
      if (ram_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", {50'd0, ram_addr}, 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {50'd0, ram_addr}, {50'd0, e[45:32]});
          chk("wr_data", {32'd0, ram_wdata}, {32'd0, e[31:0]});
          done_next = e[46];
        end
      end
      if (load_done === 1'b1 || exp_done) chk("load_done", {63'd0, load_done}, {63'd0, exp_done});
    end
  end

  // driver tasks
  task automatic pulse_start();
    load_start = 1'b1;
    exp_addr   = 14'd0;
    @(posedge gbdt_clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_beat(input logic hdr, input logic [31:0] data);
    int t;
    in_valid = 1'b1;
    in_hdr   = hdr;
    in_data  = data;
    t = 0;
    forever begin
      @(negedge gbdt_clk);
      if (in_ready === 1'b1) break;
      t++;
      if (t > 50) begin
        chk("handshake_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge gbdt_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_node(input logic [31:0] data, input logic [31:0] exp_data, input logic done);
    exp_q.push_back({done, exp_addr, exp_data});
    exp_addr = exp_addr + 14'd1;
    send_beat(1'b0, data);
  endtask

  task automatic chk_err_idle(input string name);
    chk({name, "_err"},  {63'd0, load_err}, 64'd1);
    chk({name, "_busy"}, {63'd0, busy},     64'd0);
    chk({name, "_rdy"},  {63'd0, in_ready}, 64'd0);
  endtask

  initial begin
    gbdt_rst = 1'b1; load_start = 1'b0; eng_idle = 1'b1;
    in_valid = 1'b0; in_hdr = 1'b0; in_data = 32'd0; exp_addr = 14'd0;
    repeat (3) @(posedge gbdt_clk);
    #1;
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_we",    {63'd0, ram_we},   64'd0);
    chk("rst_busy",  {63'd0, busy},     64'd0);
    chk("rst_done",  {63'd0, load_done}, 64'd0);
    chk("rst_err",   {63'd0, load_err}, 64'd0);
    chk("rst_addr",  {50'd0, ram_addr}, 64'd0);
    chk("rst_wdata", {32'd0, ram_wdata}, 64'd0);
    gbdt_rst = 1'b0;
    // In IDLE a valid beat is not accepted.
    in_valid = 1'b1; in_hdr = 1'b1; in_data = 32'd3;
    @(negedge gbdt_clk);
    chk("idle_ready", {63'd0, in_ready}, 64'd0);
    @(posedge gbdt_clk); #1;
    in_valid = 1'b0;

    // Two trees: cnt=3 not last, then cnt=1 last.
    pulse_start();
    chk("start_busy", {63'd0, busy}, 64'd1);
    send_beat(1'b1, 32'h0000_0003);
    send_node(32'h0508_0104, 32'h0508_0104, 1'b0); // internal, children at 1 and 2
    send_node(32'h1234_FFFF, 32'h1234_000D, 1'b0); // leaf, next_tree=3
    send_node(32'h0055_0001, 32'h0055_000D, 1'b0);
    send_beat(1'b1, 32'h0000_4001);
    send_node(32'hBEEF_0003, 32'hBEEF_0003, 1'b1); // leaf of last tree
    repeat (3) @(posedge gbdt_clk);
    #1;
    chk("t2_busy", {63'd0, busy}, 64'd0);

    // Internal node whose left child (0+5) lies outside a 3-node tree.
    pulse_start();
    send_beat(1'b1, 32'h0000_4003);
    send_beat(1'b0, 32'h0000_0500);
    chk_err_idle("child_oob");
    pulse_start();
    chk("err_clear", {63'd0, load_err}, 64'd0);
    chk("err_clear_busy", {63'd0, busy}, 64'd1);

    // eng_idle pause after the second node.
    send_beat(1'b1, 32'h0000_4004);
    send_node(32'h0000_0104, 32'h0000_0104, 1'b0);
    send_node(32'h1111_0001, 32'h1111_0003, 1'b0);
    eng_idle = 1'b0;
    in_valid = 1'b1; in_hdr = 1'b0; in_data = 32'h2222_0001;
    #1;
    chk("pause_ready_now", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge gbdt_clk);
      chk("pause_ready", {63'd0, in_ready}, 64'd0);
      if (i > 0) chk("pause_we", {63'd0, ram_we}, 64'd0);
    end
    @(posedge gbdt_clk); #1;
    eng_idle = 1'b1;
    send_node(32'h2222_0001, 32'h2222_0003, 1'b0);
    send_node(32'h7F00_0000, 32'h7F00_0000, 1'b1);
    repeat (3) @(posedge gbdt_clk);
    #1;

    // Protocol errors.
    pulse_start();
    send_beat(1'b1, 32'h0000_0000);
    chk_err_idle("cnt_zero");
    pulse_start();
    send_beat(1'b0, 32'h0000_0001);
    chk_err_idle("node_in_hdr");
    pulse_start();
    send_beat(1'b1, 32'h0000_4002);
    send_beat(1'b1, 32'h0000_4002);
    chk_err_idle("hdr_in_nodes");
    pulse_start();
    send_beat(1'b1, 32'h0000_0002);
    send_node(32'hAAAA_0001, 32'hAAAA_0009, 1'b0);
    send_node(32'hBBBB_0001, 32'hBBBB_0009, 1'b0);
    send_beat(1'b1, 32'h0000_3FFF); // base 2 + 16383 > 16384
    chk_err_idle("overflow");
    repeat (2) @(posedge gbdt_clk);

    // Reset during NODES while a write is on the port.
    pulse_start();
    send_beat(1'b1, 32'h0000_4003);
    send_node(32'h0000_0104, 32'h0000_0104, 1'b0);
    @(negedge gbdt_clk); #1;
    gbdt_rst = 1'b1;
    #1;
    chk("mid_rst_we",    {63'd0, ram_we},    64'd0);
    chk("mid_rst_addr",  {50'd0, ram_addr},  64'd0);
    chk("mid_rst_wdata", {32'd0, ram_wdata}, 64'd0);
    chk("mid_rst_busy",  {63'd0, busy},      64'd0);
    chk("mid_rst_ready", {63'd0, in_ready},  64'd0);
    chk("mid_rst_err",   {63'd0, load_err},  64'd0);
    @(posedge gbdt_clk); #1;
    gbdt_rst = 1'b0;
    in_valid = 1'b1; in_hdr = 1'b1; in_data = 32'h0000_4001;
    for (int i = 0; i < 3; i++) begin
      @(negedge gbdt_clk);
      chk("post_rst_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge gbdt_clk);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
